// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
//   - Forwarding select encodings (FWD_RF / FWD_MEM / FWD_WB)
//   - Control bits carried by each shadow stage
//   - Control-mode enum used by the top-level priority logic
//   - Default register-index and counter widths
//   - fwd_pick(): forwarding source choice for one EXE operand
package pipeline_ctrl_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 4;
  localparam int unsigned DEF_CNT_W      = 16;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Per-stage control bits; register indices live beside this in the top,
  // because their width follows the REG_ADDR_W parameter.
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic two_src;
  } stage_ctrl_t;

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_HAZARD,
    MODE_FLUSH,
    MODE_FREEZE
  } ctrl_mode_e;

  // A load sitting in MEM has no data yet, so a MEM hit on a load falls
  // through to the WB check.
  function automatic logic [1:0] fwd_pick(input logic mem_hit,
                                          input logic mem_is_load,
                                          input logic wb_hit);
    if (mem_hit && !mem_is_load) return FWD_MEM;
    if (wb_hit)                  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_match.sv
// Combinational source-versus-stage match.
// Ports:
//   src         in  REG_ADDR_W : source register index
//   src_used    in  1          : the source is actually read
//   stage_valid in  1          : stage holds a real instruction
//   stage_wb_en in  1          : stage instruction writes the register file
//   stage_dest  in  REG_ADDR_W : stage destination register
//   hit         out 1          : stage produces the value the source reads
module pipeline_ctrl_match
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_used,
  input  logic                  stage_valid,
  input  logic                  stage_wb_en,
  input  logic [REG_ADDR_W-1:0] stage_dest,
  output logic                  hit
);

  always_comb begin
    hit = src_used & stage_valid & stage_wb_en & (stage_dest == src);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit for the 5-stage ARM core.
// Shadows the EXE/MEM/WB instructions and produces stall, bubble, flush and
// memory-freeze controls, EXE operand forwarding selects and saturating
// performance counters.
// Build option: define PIPELINE_CTRL_FORWARDING_EN for the load-use-only
// hazard rule with forwarding; otherwise full RAW stalls and fwd_sel = 0.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   id_valid, id_src1, id_src2,
//   id_two_src, id_wb_en, id_mem_r_en,
//   id_mem_w_en, id_dest             : instruction currently in ID
//   branch_taken                     : EXE instruction is a taken branch
//   mem_ready                        : MEM-stage data access completes
//   pc_freeze, if_id_freeze          : hold PC and IF/ID
//   if_id_flush                      : clear IF/ID
//   id_exe_bubble                    : load a NOP into ID/EXE
//   pipe_freeze                      : hold ID/EXE, EXE/MEM, MEM/WB
//   fwd_sel_a, fwd_sel_b             : EXE operand source select
//   stall_cnt, freeze_cnt, flush_cnt : saturating event counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic                  id_mem_w_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  branch_taken,
  input  logic                  mem_ready,
  output logic                  pc_freeze,
  output logic                  if_id_freeze,
  output logic                  if_id_flush,
  output logic                  id_exe_bubble,
  output logic                  pipe_freeze,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      freeze_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    stage_ctrl_t           ctl;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
  } shadow_t;

  shadow_t    s_exe, s_mem, s_wb, s_exe_next;
  ctrl_mode_e mode;
  logic       mem_wait;
  logic       hazard;
  logic       id1_exe_hit, id2_exe_hit;

  pipeline_ctrl_match #(.REG_ADDR_W(REG_ADDR_W)) u_id1_exe (
    .src(id_src1), .src_used(1'b1),
    .stage_valid(s_exe.ctl.valid), .stage_wb_en(s_exe.ctl.wb_en),
    .stage_dest(s_exe.dest), .hit(id1_exe_hit)
  );

  pipeline_ctrl_match #(.REG_ADDR_W(REG_ADDR_W)) u_id2_exe (
    .src(id_src2), .src_used(id_two_src),
    .stage_valid(s_exe.ctl.valid), .stage_wb_en(s_exe.ctl.wb_en),
    .stage_dest(s_exe.dest), .hit(id2_exe_hit)
  );

  always_comb begin
    mem_wait = s_mem.ctl.valid & (s_mem.ctl.mem_r_en | s_mem.ctl.mem_w_en)
             & ~mem_ready;
  end

`ifdef PIPELINE_CTRL_FORWARDING_EN
  logic a_mem_hit, a_wb_hit, b_mem_hit, b_wb_hit;
  logic exe_src1_used, exe_src2_used;

  // Operand sources of an EXE bubble are meaningless, so never forward them.
  always_comb begin
    exe_src1_used = s_exe.ctl.valid;
    exe_src2_used = s_exe.ctl.valid & s_exe.ctl.two_src;
  end

  pipeline_ctrl_match #(.REG_ADDR_W(REG_ADDR_W)) u_a_mem (
    .src(s_exe.src1), .src_used(exe_src1_used),
    .stage_valid(s_mem.ctl.valid), .stage_wb_en(s_mem.ctl.wb_en),
    .stage_dest(s_mem.dest), .hit(a_mem_hit)
  );

  pipeline_ctrl_match #(.REG_ADDR_W(REG_ADDR_W)) u_a_wb (
    .src(s_exe.src1), .src_used(exe_src1_used),
    .stage_valid(s_wb.ctl.valid), .stage_wb_en(s_wb.ctl.wb_en),
    .stage_dest(s_wb.dest), .hit(a_wb_hit)
  );

  pipeline_ctrl_match #(.REG_ADDR_W(REG_ADDR_W)) u_b_mem (
    .src(s_exe.src2), .src_used(exe_src2_used),
    .stage_valid(s_mem.ctl.valid), .stage_wb_en(s_mem.ctl.wb_en),
    .stage_dest(s_mem.dest), .hit(b_mem_hit)
  );

  pipeline_ctrl_match #(.REG_ADDR_W(REG_ADDR_W)) u_b_wb (
    .src(s_exe.src2), .src_used(exe_src2_used),
    .stage_valid(s_wb.ctl.valid), .stage_wb_en(s_wb.ctl.wb_en),
    .stage_dest(s_wb.dest), .hit(b_wb_hit)
  );

  // Only a load in EXE cannot be forwarded in time.
  always_comb begin
    hazard    = id_valid & (id1_exe_hit | id2_exe_hit) & s_exe.ctl.mem_r_en;
    fwd_sel_a = fwd_pick(a_mem_hit, s_mem.ctl.mem_r_en, a_wb_hit);
    fwd_sel_b = fwd_pick(b_mem_hit, s_mem.ctl.mem_r_en, b_wb_hit);
  end
`else
  logic id1_mem_hit, id2_mem_hit;

  pipeline_ctrl_match #(.REG_ADDR_W(REG_ADDR_W)) u_id1_mem (
    .src(id_src1), .src_used(1'b1),
    .stage_valid(s_mem.ctl.valid), .stage_wb_en(s_mem.ctl.wb_en),
    .stage_dest(s_mem.dest), .hit(id1_mem_hit)
  );

  pipeline_ctrl_match #(.REG_ADDR_W(REG_ADDR_W)) u_id2_mem (
    .src(id_src2), .src_used(id_two_src),
    .stage_valid(s_mem.ctl.valid), .stage_wb_en(s_mem.ctl.wb_en),
    .stage_dest(s_mem.dest), .hit(id2_mem_hit)
  );

  // WB writes the register file before ID reads it, so only EXE/MEM stall.
  always_comb begin
    hazard    = id_valid & (id1_exe_hit | id2_exe_hit | id1_mem_hit | id2_mem_hit);
    fwd_sel_a = FWD_RF;
    fwd_sel_b = FWD_RF;
  end
`endif

  // Fields carried through the shadow pipe but not consumed in every build.
  logic unused_bits;
  always_comb begin
    unused_bits = ^{s_wb, s_mem.src1, s_mem.src2, s_mem.ctl.two_src};
  end

  always_comb begin
    mode = MODE_NORMAL;
    if (mem_wait)          mode = MODE_FREEZE;
    else if (branch_taken) mode = MODE_FLUSH;
    else if (hazard)       mode = MODE_HAZARD;
  end

  always_comb begin
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    pipe_freeze   = 1'b0;
    unique case (mode)
      MODE_FREEZE: begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        pipe_freeze  = 1'b1;
      end
      MODE_FLUSH: begin
        if_id_flush   = 1'b1;
        id_exe_bubble = 1'b1;
      end
      MODE_HAZARD: begin
        pc_freeze     = 1'b1;
        if_id_freeze  = 1'b1;
        id_exe_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_exe_next = '0;
    if (mode == MODE_NORMAL && id_valid) begin
      s_exe_next.ctl.valid    = 1'b1;
      s_exe_next.ctl.wb_en    = id_wb_en;
      s_exe_next.ctl.mem_r_en = id_mem_r_en;
      s_exe_next.ctl.mem_w_en = id_mem_w_en;
      s_exe_next.ctl.two_src  = id_two_src;
      s_exe_next.dest         = id_dest;
      s_exe_next.src1         = id_src1;
      s_exe_next.src2         = id_src2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_exe <= '0;
      s_mem <= '0;
      s_wb  <= '0;
    end else if (mode != MODE_FREEZE) begin
      s_exe <= s_exe_next;
      s_mem <= s_exe;
      s_wb  <= s_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (mode == MODE_HAZARD && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (mode == MODE_FREEZE && freeze_cnt != '1)
        freeze_cnt <= freeze_cnt + CNT_W'(1);
      if (mode == MODE_FLUSH && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_two_src, id_wb_en, id_mem_r_en, id_mem_w_en;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       branch_taken, mem_ready;

  logic        pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [15:0] stall_cnt, freeze_cnt, flush_cnt;

  logic        s_pc_freeze, s_if_id_freeze, s_if_id_flush, s_id_exe_bubble, s_pipe_freeze;
  logic [1:0]  s_fwd_sel_a, s_fwd_sel_b;
  logic [1:0]  s_stall_cnt, s_freeze_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PIPELINE_CTRL_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_dest(id_dest), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble), .pipe_freeze(pipe_freeze),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt),
    .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_dest(id_dest), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_freeze(s_pc_freeze), .if_id_freeze(s_if_id_freeze),
    .if_id_flush(s_if_id_flush), .id_exe_bubble(s_id_exe_bubble), .pipe_freeze(s_pipe_freeze),
    .fwd_sel_a(s_fwd_sel_a), .fwd_sel_b(s_fwd_sel_b), .stall_cnt(s_stall_cnt),
    .freeze_cnt(s_freeze_cnt), .flush_cnt(s_flush_cnt)
  );

  // Reference model: in-flight instructions at EXE(0), MEM(1), WB(2).
  typedef struct {
    bit valid; bit wb; bit ld; bit st; bit two;
    int dest; int s1; int s2;
  } instr_t;

  instr_t pipe [3];
  int m_stall, m_freeze, m_flush;

  function automatic bit writes(instr_t p, int r, bit used);
    return used && p.valid && p.wb && (p.dest == r);
  endfunction

  function automatic bit id_reads(instr_t p);
    return id_valid && (writes(p, int'(id_src1), 1'b1) || writes(p, int'(id_src2), id_two_src));
  endfunction

  // {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze}
  function automatic logic [4:0] exp_ctrl();
    bit mw, hz;
    mw = pipe[1].valid && (pipe[1].ld || pipe[1].st) && !mem_ready;
    if (FWD_ON) hz = id_reads(pipe[0]) && pipe[0].ld;
    else        hz = id_reads(pipe[0]) || id_reads(pipe[1]);
    if (mw)           return 5'b11001;
    if (branch_taken) return 5'b00110;
    if (hz)           return 5'b11010;
    return 5'b00000;
  endfunction

  function automatic logic [1:0] exp_fwd(int src, bit used);
    if (!FWD_ON || !pipe[0].valid || !used) return 2'd0;
    if (writes(pipe[1], src, 1'b1) && !pipe[1].ld) return 2'd1;
    if (writes(pipe[2], src, 1'b1)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_tick();
    logic [4:0] c;
    instr_t n;
    c = exp_ctrl();
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
      m_stall = 0; m_freeze = 0; m_flush = 0;
    end else if (c[0]) begin
      m_freeze++;
    end else begin
      if (c[2]) m_flush++;
      if (c == 5'b11010) m_stall++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      n = '{default: 0};
      if (c == 5'b00000 && id_valid) begin
        n.valid = 1'b1; n.wb = id_wb_en; n.ld = id_mem_r_en; n.st = id_mem_w_en;
        n.two = id_two_src; n.dest = int'(id_dest); n.s1 = int'(id_src1); n.s2 = int'(id_src2);
      end
      pipe[0] = n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic set_id(bit v, logic [3:0] s1, logic [3:0] s2, bit two, bit wb,
                        bit ld, bit st, logic [3:0] d);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_wb_en = wb; id_mem_r_en = ld; id_mem_w_en = st; id_dest = d;
  endtask

  task automatic set_idle();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; set_idle(); branch_taken = 1'b0; mem_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; branch_taken = 1'b1; mem_ready = 1'b0;
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    rst = 1'b0; branch_taken = 1'b0; mem_ready = 1'b1; set_idle();
    @(negedge clk);
    n_tests++;
    if ({pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000",
        {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze});
    end
    n_tests++;
    if ({fwd_sel_a, fwd_sel_b} !== 4'b0) begin
      n_fail++; $display("FAIL reset_fwd: got a=%0d b=%0d want 0 0", fwd_sel_a, fwd_sel_b);
    end
    n_tests++;
    if ({stall_cnt, freeze_cnt, flush_cnt} !== 48'b0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0", stall_cnt, freeze_cnt, flush_cnt);
    end
  endtask

  task automatic test_raw_pair();
    do_reset();
    set_id(1'b1, 4'd3, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);  // ADD R1
    tick();
    set_id(1'b1, 4'd1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5);  // SUB R5, R1, R6
`ifdef PIPELINE_CTRL_FORWARDING_EN
    @(negedge clk);
    n_tests++;
    if (pc_freeze !== 1'b0 || id_exe_bubble !== 1'b0) begin
      n_fail++; $display("FAIL raw_nostall: got pc_freeze=%b bubble=%b want 0 0", pc_freeze, id_exe_bubble);
    end
    tick(); set_idle();
    @(negedge clk);
    n_tests++;
    if (fwd_sel_a !== 2'd1) begin
      n_fail++; $display("FAIL raw_fwd_mem: got fwd_sel_a=%0d want 1", fwd_sel_a);
    end
`else
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (pc_freeze !== 1'b1 || id_exe_bubble !== 1'b1) begin
        n_fail++; $display("FAIL raw_stall%0d: got pc_freeze=%b bubble=%b want 1 1", i, pc_freeze, id_exe_bubble);
      end
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (pc_freeze !== 1'b0) begin
      n_fail++; $display("FAIL raw_release: got pc_freeze=%b want 0", pc_freeze);
    end
    tick(); set_idle();
    @(negedge clk);
    n_tests++;
    if (fwd_sel_a !== 2'd0) begin
      n_fail++; $display("FAIL raw_fwd_off: got fwd_sel_a=%0d want 0", fwd_sel_a);
    end
`endif
    n_tests++;
    if (stall_cnt !== (FWD_ON ? 16'd0 : 16'd2)) begin
      n_fail++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, FWD_ON ? 0 : 2);
    end
  endtask

  task automatic test_load_use();
    int nst;
    nst = FWD_ON ? 1 : 2;
    do_reset();
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);  // LDR R2, [R3]
    tick();
    set_id(1'b1, 4'd2, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7);  // ADD R7, R2, R8
    for (int i = 0; i < nst; i++) begin
      @(negedge clk);
      n_tests++;
      if (pc_freeze !== 1'b1 || id_exe_bubble !== 1'b1 || if_id_flush !== 1'b0) begin
        n_fail++; $display("FAIL lu_stall%0d: got pc_freeze=%b bubble=%b flush=%b want 1 1 0",
                           i, pc_freeze, id_exe_bubble, if_id_flush);
      end
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (pc_freeze !== 1'b0) begin
      n_fail++; $display("FAIL lu_release: got pc_freeze=%b want 0", pc_freeze);
    end
    n_tests++;
    if (stall_cnt !== 16'(nst)) begin
      n_fail++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, nst);
    end
    tick(); set_idle();
    @(negedge clk);
    n_tests++;
    if (fwd_sel_a !== (FWD_ON ? 2'd2 : 2'd0)) begin
      n_fail++; $display("FAIL lu_fwd_wb: got fwd_sel_a=%0d want %0d", fwd_sel_a, FWD_ON ? 2 : 0);
    end
  endtask

  task automatic test_mem_freeze();
    do_reset();
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);  // STR R2, [R1]
    tick();
    set_id(1'b1, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);  // ADD R3
    mem_ready = 1'b0;
    tick();
    set_id(1'b1, 4'd3, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9);  // SUB R9, R3, R7
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (pipe_freeze !== 1'b1 || pc_freeze !== 1'b1 || id_exe_bubble !== 1'b0) begin
        n_fail++; $display("FAIL mf_freeze%0d: got pipe=%b pc=%b bubble=%b want 1 1 0",
                           i, pipe_freeze, pc_freeze, id_exe_bubble);
      end
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (pipe_freeze !== 1'b0 || freeze_cnt !== 16'd3) begin
      n_fail++; $display("FAIL mf_release: got pipe=%b freeze_cnt=%0d want 0 3", pipe_freeze, freeze_cnt);
    end
    // ADD must still be in EXE after the freeze.
    n_tests++;
    if (pc_freeze !== !FWD_ON) begin
      n_fail++; $display("FAIL mf_hold_exe: got pc_freeze=%b want %b", pc_freeze, !FWD_ON);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (pc_freeze !== !FWD_ON || fwd_sel_a !== (FWD_ON ? 2'd1 : 2'd0)) begin
      n_fail++; $display("FAIL mf_after: got pc_freeze=%b fwd_a=%0d want %b %0d",
                         pc_freeze, fwd_sel_a, !FWD_ON, FWD_ON ? 1 : 0);
    end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);  // LDR R2
    tick();
    set_id(1'b1, 4'd2, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7);  // ADD uses R2
    branch_taken = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze} !== 5'b00110) begin
      n_fail++; $display("FAIL br_hz_ctrl: got %b want 00110",
        {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze});
    end
    tick();
    branch_taken = 1'b0; set_idle();
    @(negedge clk);
    n_tests++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL br_hz_cnt: got flush=%0d stall=%0d want 1 0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_branch_in_freeze();
    do_reset();
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);  // STR
    tick();
    set_idle(); mem_ready = 1'b0;
    tick();
    branch_taken = 1'b1;
    @(negedge clk);
    n_tests++;
    if (if_id_flush !== 1'b0 || pipe_freeze !== 1'b1) begin
      n_fail++; $display("FAIL bf_masked: got flush=%b pipe=%b want 0 1", if_id_flush, pipe_freeze);
    end
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (if_id_flush !== 1'b1 || pipe_freeze !== 1'b0) begin
      n_fail++; $display("FAIL bf_acted: got flush=%b pipe=%b want 1 0", if_id_flush, pipe_freeze);
    end
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    n_tests++;
    if (flush_cnt !== 16'd1 || freeze_cnt !== 16'd1) begin
      n_fail++; $display("FAIL bf_cnt: got flush=%0d freeze=%0d want 1 1", flush_cnt, freeze_cnt);
    end
  endtask

  task automatic test_saturation();
    int budget;
    do_reset();
    set_id(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);  // LDR R2, [R2] repeatedly
    budget = 0;
    while (m_stall < 5 && budget < 40) begin
      tick();
      budget++;
    end
    set_idle();
    @(negedge clk);
    n_tests++;
    if (stall_cnt !== 16'd5 || s_stall_cnt !== 2'd3) begin
      n_fail++; $display("FAIL sat_stall: got wide=%0d narrow=%0d want 5 3", stall_cnt, s_stall_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({s_stall_cnt, s_freeze_cnt, s_flush_cnt, stall_cnt} !== 22'b0) begin
      n_fail++; $display("FAIL sat_reset: got narrow=%0d/%0d/%0d wide=%0d want 0",
                         s_stall_cnt, s_freeze_cnt, s_flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] ec;
    logic [4:0] gc, sc;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst          = ($urandom_range(99) == 0);
      id_valid     = ($urandom_range(9) < 8);
      id_src1      = 4'($urandom_range(3));
      id_src2      = 4'($urandom_range(3));
      id_dest      = 4'($urandom_range(3));
      id_two_src   = 1'($urandom_range(1));
      id_mem_r_en  = ($urandom_range(3) == 0);
      id_mem_w_en  = !id_mem_r_en && ($urandom_range(5) == 0);
      id_wb_en     = id_mem_r_en || (!id_mem_w_en && ($urandom_range(4) != 0));
      branch_taken = ($urandom_range(9) == 0);
      mem_ready    = ($urandom_range(3) != 0);
      @(negedge clk);
      ec = exp_ctrl();
      gc = {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_freeze};
      sc = {s_pc_freeze, s_if_id_freeze, s_if_id_flush, s_id_exe_bubble, s_pipe_freeze};
      n_tests++;
      if (gc !== ec || sc !== ec) begin
        n_fail++; $display("FAIL rnd_ctrl @%0d: got %b/%b want %b", cyc, gc, sc, ec);
      end
      n_tests++;
      if (fwd_sel_a !== exp_fwd(pipe[0].s1, 1'b1) || fwd_sel_b !== exp_fwd(pipe[0].s2, pipe[0].two)) begin
        n_fail++; $display("FAIL rnd_fwd @%0d: got a=%0d b=%0d want a=%0d b=%0d", cyc,
                           fwd_sel_a, fwd_sel_b, exp_fwd(pipe[0].s1, 1'b1), exp_fwd(pipe[0].s2, pipe[0].two));
      end
      n_tests++;
      if (stall_cnt !== 16'(sat(m_stall, 65535)) || freeze_cnt !== 16'(sat(m_freeze, 65535)) ||
          flush_cnt !== 16'(sat(m_flush, 65535))) begin
        n_fail++; $display("FAIL rnd_cnt @%0d: got %0d %0d %0d want %0d %0d %0d", cyc,
                           stall_cnt, freeze_cnt, flush_cnt, m_stall, m_freeze, m_flush);
      end
      n_tests++;
      if (s_stall_cnt !== 2'(sat(m_stall, 3)) || s_freeze_cnt !== 2'(sat(m_freeze, 3)) ||
          s_flush_cnt !== 2'(sat(m_flush, 3))) begin
        n_fail++; $display("FAIL rnd_satcnt @%0d: got %0d %0d %0d want %0d %0d %0d", cyc,
                           s_stall_cnt, s_freeze_cnt, s_flush_cnt,
                           sat(m_stall, 3), sat(m_freeze, 3), sat(m_flush, 3));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    m_stall = 0; m_freeze = 0; m_flush = 0;
    rst = 1'b0; branch_taken = 1'b0; mem_ready = 1'b1;
    set_idle();
    test_reset();
    test_raw_pair();
    test_load_use();
    test_mem_freeze();
    test_branch_hazard();
    test_branch_in_freeze();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
